// File: rtl/text_memory_arbiter.sv
// text_memory_arbiter
// Shares the single-port text (instruction) memory between core instruction
// fetch and the program-loader/debug port.
//  - SHARED: fetch has fixed priority; a loader blocked for STARVE_LIMIT cycles
//    wins the next slot.
//  - DRAIN: one cycle after load_lock is seen, so an in-flight fetch response
//    can complete while the core is already told to stall.
//  - EXCLUSIVE: loader owns the memory; the core is stalled.
// The memory is external: combinational read of mem_address and a write that
// commits at the clock edge that accepts the loader write.
// Optional build macro: TEXT_ARB_PERF_EN adds the perf_fetch_stall and
// perf_load_wait saturating event counters.
module text_memory_arbiter #(
    parameter int TEXT_BITS    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [TEXT_BITS-3:0] fetch_address,
    output logic                 fetch_ready,
    output logic                 fetch_rvalid,
    output logic [31:0]          fetch_rdata,
    input  logic                 load_req,
    input  logic                 load_we,
    input  logic [TEXT_BITS-3:0] load_address,
    input  logic [31:0]          load_wdata,
    output logic                 load_ready,
    output logic                 load_rvalid,
    output logic [31:0]          load_rdata,
    input  logic                 load_lock,
    output logic                 core_stall,
    output logic [TEXT_BITS-3:0] mem_address,
    output logic                 mem_we,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
`ifdef TEXT_ARB_PERF_EN
    ,
    output logic [31:0]          perf_fetch_stall,
    output logic [31:0]          perf_load_wait
`endif
);

    localparam int WW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] LIMIT_W = WW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        SHARED    = 2'd0,
        DRAIN     = 2'd1,
        EXCLUSIVE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [WW-1:0]   wait_cnt_reg;
    logic            starve;

    // Read-return channels: index 0 = fetch, index 1 = loader.
    logic            rd_accept [2];
    logic            rvalid_reg [2];
    logic [31:0]     rdata_reg  [2];

    genvar gi;

    // Grant selection and memory-side muxing; nothing is granted while in reset.
    always_comb begin
        starve      = (wait_cnt_reg == LIMIT_W);
        fetch_ready = 1'b0;
        load_ready  = 1'b0;
        if (!reset) begin
            case (state_reg)
                SHARED: begin
                    if (load_lock) begin
                        // Lock request: fetch is held off in the transition cycle.
                        load_ready = load_req;
                    end else begin
                        fetch_ready = fetch_req && !starve;
                        load_ready  = load_req && (!fetch_req || starve);
                    end
                end
                default: load_ready = load_req;
            endcase
        end
        if (fetch_ready) begin
            mem_address = fetch_address;
        end else if (load_ready) begin
            mem_address = load_address;
        end else begin
            mem_address = '0;
        end
        mem_we    = load_ready && load_we;
        mem_wdata = mem_we ? load_wdata : 32'h0;
    end

    assign core_stall   = (state_reg != SHARED);
    assign rd_accept[0] = fetch_ready;
    assign rd_accept[1] = load_ready && !load_we;

    // Ownership state machine: SHARED -> DRAIN -> EXCLUSIVE while load_lock is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= SHARED;
        end else begin
            case (state_reg)
                SHARED:    if (load_lock) state_reg <= DRAIN;
                DRAIN:     state_reg <= load_lock ? EXCLUSIVE : SHARED;
                EXCLUSIVE: if (!load_lock) state_reg <= SHARED;
                default:   state_reg <= SHARED;
            endcase
        end
    end

    // Counts consecutive cycles the loader is refused; saturates at the starve limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else if (load_req && !load_ready) begin
            if (wait_cnt_reg != LIMIT_W) begin
                wait_cnt_reg <= wait_cnt_reg + WW'(1);
            end
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            // Capture read data at the accepting edge; rdata holds until the next read.
            always_ff @(posedge clock) begin
                if (reset) begin
                    rvalid_reg[gi] <= 1'b0;
                    rdata_reg[gi]  <= 32'h0;
                end else begin
                    rvalid_reg[gi] <= rd_accept[gi];
                    if (rd_accept[gi]) begin
                        rdata_reg[gi] <= mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign fetch_rvalid = rvalid_reg[0];
    assign fetch_rdata  = rdata_reg[0];
    assign load_rvalid  = rvalid_reg[1];
    assign load_rdata   = rdata_reg[1];

`ifdef TEXT_ARB_PERF_EN
    logic        perf_event [2];
    logic [31:0] perf_cnt_reg [2];

    assign perf_event[0] = fetch_req && !fetch_ready;
    assign perf_event[1] = load_req && !load_ready;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            // Saturating count of cycles a requester was refused.
            always_ff @(posedge clock) begin
                if (reset) begin
                    perf_cnt_reg[gi] <= 32'h0;
                end else if (perf_event[gi] && (perf_cnt_reg[gi] != 32'hFFFF_FFFF)) begin
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_fetch_stall = perf_cnt_reg[0];
    assign perf_load_wait   = perf_cnt_reg[1];
`endif

endmodule

// File: tb/tb_text_memory_arbiter.sv
// Testbench for text_memory_arbiter: directed tables/sequences for the
// documented scenarios plus randomized traffic checked against a rule-level
// reference model. Define TEXT_ARB_PERF_EN to also check the perf counters.
module tb_text_memory_arbiter;

    localparam int TEXT_BITS = 10;
    localparam int AW        = TEXT_BITS - 2;
    localparam int DEPTH     = 1 << AW;
    localparam int LIMIT     = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          fetch_req;
    logic [AW-1:0] fetch_address;
    logic          fetch_ready;
    logic          fetch_rvalid;
    logic [31:0]   fetch_rdata;
    logic          load_req;
    logic          load_we;
    logic [AW-1:0] load_address;
    logic [31:0]   load_wdata;
    logic          load_ready;
    logic          load_rvalid;
    logic [31:0]   load_rdata;
    logic          load_lock;
    logic          core_stall;
    logic [AW-1:0] mem_address;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
`ifdef TEXT_ARB_PERF_EN
    logic [31:0]   perf_fetch_stall;
    logic [31:0]   perf_load_wait;
`endif

    always #5 clock = ~clock;

    text_memory_arbiter #(
        .TEXT_BITS    (TEXT_BITS),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .fetch_req     (fetch_req),
        .fetch_address (fetch_address),
        .fetch_ready   (fetch_ready),
        .fetch_rvalid  (fetch_rvalid),
        .fetch_rdata   (fetch_rdata),
        .load_req      (load_req),
        .load_we       (load_we),
        .load_address  (load_address),
        .load_wdata    (load_wdata),
        .load_ready    (load_ready),
        .load_rvalid   (load_rvalid),
        .load_rdata    (load_rdata),
        .load_lock     (load_lock),
        .core_stall    (core_stall),
        .mem_address   (mem_address),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
`ifdef TEXT_ARB_PERF_EN
        ,
        .perf_fetch_stall (perf_fetch_stall),
        .perf_load_wait   (perf_load_wait)
`endif
    );

    // Text memory attached to the DUT: combinational read, clocked write.
    logic        mem_init;
    logic [31:0] mem [DEPTH];
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (mem_we) begin
            mem[mem_address] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_address];

    // Reference model state.
    int          m_mode;   // 0 shared, 1 drain, 2 exclusive
    int          m_wait;
    logic        m_frv, m_lrv;
    logic [31:0] m_frd, m_lrd;
    logic [31:0] ref_mem [DEPTH];
`ifdef TEXT_ARB_PERF_EN
    logic [31:0] m_pfs, m_plw;
`endif

    int tests = 0;
    int fails = 0;
    logic s_fr, s_lr, s_stall;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check every output against the model at
    // the falling edge, then advance the model at the rising edge.
    task automatic step(input logic rst, input logic fq, input logic [AW-1:0] fa,
                        input logic lq, input logic lwe, input logic [AW-1:0] la,
                        input logic [31:0] lwd, input logic lk);
        logic starve, e_fr, e_lr, e_we;
        logic [AW-1:0] e_addr;
        reset = rst; fetch_req = fq; fetch_address = fa;
        load_req = lq; load_we = lwe; load_address = la; load_wdata = lwd; load_lock = lk;
        @(negedge clock);
        starve = (m_wait >= LIMIT);
        e_fr = 1'b0;
        e_lr = 1'b0;
        if (!rst) begin
            if (m_mode != 0 || lk) begin
                e_lr = lq;
            end else begin
                e_fr = fq && !starve;
                e_lr = lq && (!fq || starve);
            end
        end
        e_we   = e_lr && lwe;
        e_addr = e_fr ? fa : (e_lr ? la : '0);
        chk("fetch_ready", fetch_ready, e_fr);
        chk("load_ready", load_ready, e_lr);
        chk("core_stall", core_stall, m_mode != 0);
        chk("mem_address", mem_address, e_addr);
        chk("mem_we", mem_we, e_we);
        if (e_we) chk("mem_wdata", mem_wdata, lwd);
        chk("fetch_rvalid", fetch_rvalid, m_frv);
        chk("fetch_rdata", fetch_rdata, m_frd);
        chk("load_rvalid", load_rvalid, m_lrv);
        chk("load_rdata", load_rdata, m_lrd);
`ifdef TEXT_ARB_PERF_EN
        chk("perf_fetch_stall", perf_fetch_stall, m_pfs);
        chk("perf_load_wait", perf_load_wait, m_plw);
`endif
        s_fr = fetch_ready;
        s_lr = load_ready;
        s_stall = core_stall;
        @(posedge clock);
        if (rst) begin
            m_mode = 0; m_wait = 0;
            m_frv = 0; m_lrv = 0; m_frd = 0; m_lrd = 0;
`ifdef TEXT_ARB_PERF_EN
            m_pfs = 0; m_plw = 0;
`endif
        end else begin
`ifdef TEXT_ARB_PERF_EN
            if (fq && !e_fr && m_pfs != 32'hFFFF_FFFF) m_pfs = m_pfs + 1;
            if (lq && !e_lr && m_plw != 32'hFFFF_FFFF) m_plw = m_plw + 1;
`endif
            m_frv = e_fr;
            if (e_fr) m_frd = ref_mem[fa];
            m_lrv = e_lr && !lwe;
            if (e_lr && !lwe) m_lrd = ref_mem[la];
            if (e_we) ref_mem[la] = lwd;
            if (lq && !e_lr) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
            else m_wait = 0;
            if (m_mode == 0) m_mode = lk ? 1 : 0;
            else m_mode = lk ? 2 : 0;
        end
        #1;
    endtask

    typedef struct {
        logic fq;
        logic lq;
        logic efr;
        logic elr;
    } vec_t;

    vec_t t2 [10];

    initial begin
        logic lk_r, lq_r;
        t2 = '{'{1,1,1,0}, '{1,1,1,0}, '{1,1,1,0}, '{1,1,1,0}, '{1,1,0,1},
               '{1,1,1,0}, '{1,1,1,0}, '{1,1,1,0}, '{1,1,1,0}, '{1,1,0,1}};
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
        m_mode = 0; m_wait = 0; m_frv = 0; m_lrv = 0; m_frd = 0; m_lrd = 0;
`ifdef TEXT_ARB_PERF_EN
        m_pfs = 0; m_plw = 0;
`endif
        reset = 1; fetch_req = 0; fetch_address = 0; load_req = 0; load_we = 0;
        load_address = 0; load_wdata = 0; load_lock = 0; mem_init = 1;
        @(posedge clock); #1;
        mem_init = 0;
        @(posedge clock); #1;

        // Reset state, then streaming fetch of words 0..7.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, AW'(i), 0, 0, 0, 0, 0);
            chk("t1_rvalid", fetch_rvalid, 1);
            chk("t1_rdata", fetch_rdata, 32'h1000_0000 + 32'(i));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Fetch vs blocked loader: loader wins every fifth cycle.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, t2[i].fq, AW'(i), t2[i].lq, 0, AW'(8'h20 + i), 0, 0);
            chk("t2_fetch_ready", s_fr, t2[i].efr);
            chk("t2_load_ready", s_lr, t2[i].elr);
        end
`ifdef TEXT_ARB_PERF_EN
        chk("t6_perf_fetch_stall", perf_fetch_stall, 2);
        chk("t6_perf_load_wait", perf_load_wait, 8);
`endif

        // Lock with a fetch in flight, loader write/read-back in EXCLUSIVE.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 0, 0, 0, 0, 0);
        chk("t3_inflight_rvalid", fetch_rvalid, 1);
        chk("t3_inflight_rdata", fetch_rdata, 32'h1000_0003);
        step(0, 1, 4, 0, 0, 0, 0, 1);
        chk("t3_lock_fetch_ready", s_fr, 0);
        step(0, 1, 4, 0, 0, 0, 0, 1);
        chk("t3_drain_stall", s_stall, 1);
        chk("t3_drain_fetch_ready", s_fr, 0);
        step(0, 1, 4, 1, 1, 8'h10, 32'hDEAD_BEEF, 1);
        chk("t3_excl_write_ready", s_lr, 1);
        chk("t3_excl_stall", s_stall, 1);
        step(0, 1, 4, 1, 0, 8'h10, 0, 1);
        chk("t3_readback_rvalid", load_rvalid, 1);
        chk("t3_readback_rdata", load_rdata, 32'hDEAD_BEEF);

        // Release lock: stall drops the next cycle, fetch sees the new word.
        step(0, 1, 8'h10, 0, 0, 0, 0, 0);
        chk("t4_release_stall", s_stall, 1);
        step(0, 1, 8'h10, 0, 0, 0, 0, 0);
        chk("t4_shared_stall", s_stall, 0);
        chk("t4_shared_fetch_ready", s_fr, 1);
        chk("t4_fetch_rdata", fetch_rdata, 32'hDEAD_BEEF);

        // Reset right after a fetch accept: no further response, outputs cleared.
        step(0, 1, 5, 0, 0, 0, 0, 0);
        step(1, 1, 6, 0, 0, 0, 0, 0);
        chk("t5_reset_fetch_ready", s_fr, 0);
        chk("t5_rvalid_after_reset", fetch_rvalid, 0);
        chk("t5_rdata_after_reset", fetch_rdata, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_stall_after_reset", s_stall, 0);

        // Randomized traffic against the model.
        lk_r = 0;
        lq_r = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) lk_r = ~lk_r;
            if ($urandom_range(0, 5) == 0) lq_r = ~lq_r;
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
                 AW'($urandom_range(0, 15)), lq_r, $urandom_range(0, 2) == 0,
                 AW'($urandom_range(0, 15)), $urandom, lk_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
